vga_escalonador_embarcacoes: RTL



---
 rtl/vga_escalonador_embarcacoes.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_escalonador_embarcacoes.sv
// Ship-layer scheduler: each frame, walks all ship vectors into a shadow 8x8 map, then swaps it into the display map.
// Latency: the walk takes 2+N_EMB*MAX_CELULAS cycles; rgb_* is registered 1 cycle after linha/coluna/areaAtiva.
// Backpressure: none. A new inicioQuadro restarts the walk. Optional white grid via macro VGA_GRADE_EN.
module vga_escalonador_embarcacoes #(
   parameter int N_EMB       = 5,   // up to 8 (3-bit ship id)
   parameter int MAX_CELULAS = 5,   // up to 7 (3-bit cell count)
   parameter int ORIGEM      = 16,
   parameter int PASSO_X     = 62,
   parameter int PASSO_Y     = 57,
   parameter int LARGURA     = 54,
   parameter int ALTURA      = 49
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inicioQuadro,
   input  logic                   areaAtiva,
   input  logic [9:0]             linha,
   input  logic [9:0]             coluna,
   input  logic [64*N_EMB-1:0]    posicoesEmbarcacoes,
   input  logic [N_EMB-1:0]       visivel,
   output logic                   rgb_r,
   output logic                   rgb_g,
   output logic                   rgb_b,
   output logic                   ocupado,
   output logic                   quadroPronto
);

   typedef enum logic [1:0] {OCIOSO, LIMPA, VARRE, TROCA} estado_t;

   localparam logic [2:0] MAXC  = 3'(MAX_CELULAS);
   localparam logic [2:0] K_ULT = 3'(MAX_CELULAS - 1);
   localparam logic [2:0] I_ULT = 3'(N_EMB - 1);

   estado_t             state_q, state_d;
   logic [2:0]          i_q, i_d, k_q, k_d;
   logic [64*N_EMB-1:0] snap_pos_q;
   logic [N_EMB-1:0]    snap_vis_q;
   // Map entry: {valido, id[2:0]}, index = (Y-1)*8 + (X-1)
   logic [3:0]          sombra_q [64];
   logic [3:0]          quadro_q [64];

   logic                latch, limpa, escreve, troca;
   int                  base;
   logic [2:0]          cnt_raw, cnt;
   logic [3:0]          cel_x, cel_y;
   logic [5:0]          cel_idx;

   int                  col_i, lin_i;
   logic [2:0]          cx, cy;
   logic                cx_ok, cy_ok;
   logic [3:0]          ent;
   logic [2:0]          rgb_d, rgb_q;

   function automatic logic [2:0] cor(input logic [2:0] id);
      case (id)
         3'd0:    cor = 3'b010;
         3'd1:    cor = 3'b100;
         3'd2:    cor = 3'b110;
         3'd3:    cor = 3'b101;
         3'd4:    cor = 3'b011;
         default: cor = 3'b000;
      endcase
   endfunction

   // Decode the (ship, cell) currently addressed by the walk from the snapshot
   always_comb begin
      base    = 64*int'(i_q) + 8*int'(k_q);
      cnt_raw = snap_pos_q[64*int'(i_q) +: 3];
      cnt     = (cnt_raw > MAXC) ? MAXC : cnt_raw;
      cel_x   = snap_pos_q[base+3 +: 4];
      cel_y   = snap_pos_q[base+7 +: 4];
      // low 3 bits minus one maps 1..8 onto 0..7; out-of-range values never write
      cel_idx = {cel_y[2:0] - 3'd1, cel_x[2:0] - 3'd1};
   end

   // Next-state and control: a frame pulse in any state re-latches and restarts
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      k_d     = k_q;
      latch   = 1'b0;
      limpa   = 1'b0;
      escreve = 1'b0;
      troca   = 1'b0;
      case (state_q)
         OCIOSO: ;
         LIMPA: begin
            limpa   = 1'b1;
            i_d     = '0;
            k_d     = '0;
            state_d = VARRE;
         end
         VARRE: begin
            // first writer wins, so lower ship index owns overlapping cells
            escreve = (k_q < cnt) && snap_vis_q[i_q] &&
                      (cel_x != 4'd0) && (cel_x <= 4'd8) &&
                      (cel_y != 4'd0) && (cel_y <= 4'd8) &&
                      !sombra_q[cel_idx][3];
            if (k_q == K_ULT) begin
               k_d = '0;
               if (i_q == I_ULT) state_d = TROCA;
               else              i_d     = i_q + 3'd1;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         TROCA: begin
            troca   = 1'b1;
            state_d = OCIOSO;
         end
         default: state_d = OCIOSO;
      endcase
      if (inicioQuadro) begin
         latch   = 1'b1;
         escreve = 1'b0;
         troca   = 1'b0;
         state_d = LIMPA;
      end
   end

   // State, walk indices and the input snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OCIOSO;
         i_q        <= '0;
         k_q        <= '0;
         snap_pos_q <= '0;
         snap_vis_q <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         k_q     <= k_d;
         if (latch) begin
            snap_pos_q <= posicoesEmbarcacoes;
            snap_vis_q <= visivel;
         end
      end
   end

   // Shadow map: cleared at walk start, one cell written per walk cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 64; j++) sombra_q[j] <= 4'd0;
      end else if (limpa) begin
         for (int j = 0; j < 64; j++) sombra_q[j] <= 4'd0;
      end else if (escreve) begin
         sombra_q[cel_idx] <= {1'b1, i_q};
      end
   end

   // Display map: replaced in one cycle so a frame never sees a half-built map
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 64; j++) quadro_q[j] <= 4'd0;
      end else if (troca) begin
         quadro_q <= sombra_q;
      end
   end

   // Pixel to board cell lookup (borders exclusive) and colour selection
   always_comb begin
      col_i = int'(coluna);
      lin_i = int'(linha);
      cx    = '0;
      cy    = '0;
      cx_ok = 1'b0;
      cy_ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (col_i > ORIGEM + PASSO_X*c && col_i < ORIGEM + PASSO_X*c + LARGURA) begin
            cx_ok = 1'b1;
            cx    = 3'(c);
         end
         if (lin_i > ORIGEM + PASSO_Y*c && lin_i < ORIGEM + PASSO_Y*c + ALTURA) begin
            cy_ok = 1'b1;
            cy    = 3'(c);
         end
      end
      ent   = quadro_q[{cy, cx}];
      rgb_d = 3'b000;
      if (areaAtiva && cx_ok && cy_ok && ent[3]) begin
         rgb_d = cor(ent[2:0]);
      end
`ifdef VGA_GRADE_EN
      else if (areaAtiva && !(cx_ok && cy_ok) &&
               col_i >= ORIGEM && col_i < ORIGEM + 8*PASSO_X &&
               lin_i >= ORIGEM && lin_i < ORIGEM + 8*PASSO_Y) begin
         rgb_d = 3'b111;
      end
`endif
   end

   // Registered colour output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb_q <= 3'b000;
      else        rgb_q <= rgb_d;
   end

   assign rgb_r        = rgb_q[2];
   assign rgb_g        = rgb_q[1];
   assign rgb_b        = rgb_q[0];
   assign ocupado      = (state_q != OCIOSO);
   assign quadroPronto = troca;

endmodule
